// File: rtl/dd_pkg.sv
// Shared definitions for the gameplay path: lane bits, chart entry layout,
// scheduler state encoding and the system clock rate.
package dd_pkg;

   // Lane-mask bit positions (L,D,U,R)
   localparam int LANE_L = 3;
   localparam int LANE_D = 2;
   localparam int LANE_U = 1;
   localparam int LANE_R = 0;

   // Chart entry layout: [31:28] lane mask, [27:20] reserved, [19:0] hit time in ms
   localparam int LANES_MSB = 31;
   localparam int LANES_LSB = 28;
   localparam int HIT_MSB   = 19;

   // An all-zero lane mask terminates the chart
   localparam logic [3:0] CHART_END = 4'b0000;

   localparam int CLK_HZ = 50_000_000;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      ARMED,
      DONE
   } sched_state_e;

endpackage

// File: rtl/ms_timebase.sv
// Song millisecond clock: a prescaler dividing the system clock down to 1 ms
// ticks and a saturating millisecond counter. Run advances, hold freezes,
// clear rewinds to zero.
module ms_timebase #(
   parameter int CLKS_PER_MS = 50000,
   parameter int MS_W        = 20
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            run,
   input  logic            hold,
   input  logic            clear,
   output logic [MS_W-1:0] song_ms
);

   localparam int              PS_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_MS - 1);
   localparam logic [MS_W-1:0] MS_MAX  = '1;

   logic [PS_W-1:0] prescaler_reg;
   logic [MS_W-1:0] song_ms_reg;

   // Prescaler wraps every CLKS_PER_MS run cycles and bumps song_ms, which
   // sticks at its maximum instead of wrapping
   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         prescaler_reg <= '0;
         song_ms_reg   <= '0;
      end else if (run && !hold) begin
         if (prescaler_reg == PS_LAST) begin
            prescaler_reg <= '0;
            if (song_ms_reg != MS_MAX) begin
               song_ms_reg <= song_ms_reg + 1'b1;
            end
         end else begin
            prescaler_reg <= prescaler_reg + 1'b1;
         end
      end
   end

   assign song_ms = song_ms_reg;

endmodule

// File: rtl/note_scheduler.sv
// Chart reader: walks the step-chart ROM in order and emits one spawn pulse
// per entry LEAD_MS before its hit time. Freezes on pause, rewinds when the
// song is abandoned or ends.
module note_scheduler
   import dd_pkg::*;
#(
   parameter int CLKS_PER_MS = CLK_HZ / 1000,
   parameter int LEAD_MS     = 2000,
   parameter int ADDR_W      = 10,
   parameter int MS_W        = 20
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              game_active,
   input  logic              show_pause_screen,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic              note_valid,
   output logic [3:0]        note_lanes,
   output logic [MS_W-1:0]   note_hit_ms,
   output logic [MS_W-1:0]   song_ms,
   output logic              chart_done
);

   localparam logic [MS_W:0]     LEAD_EXT = (MS_W + 1)'(LEAD_MS);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   logic run, hold, rewind;
   logic spawn_ok;
   logic reserved_unused;

   sched_state_e      state_reg, state_next;
   logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
   logic [3:0]        entry_lanes_reg, entry_lanes_next;
   logic [MS_W-1:0]   entry_ms_reg, entry_ms_next;
   logic              note_valid_reg, note_valid_next;
   logic [3:0]        note_lanes_reg, note_lanes_next;
   logic [MS_W-1:0]   note_hit_ms_reg, note_hit_ms_next;

   assign run    = game_active;
   assign hold   = show_pause_screen & ~game_active;
   assign rewind = ~game_active & ~show_pause_screen;

   // Reserved chart bits carry nothing for the scheduler
   assign reserved_unused = ^rom_data[LANES_LSB-1:HIT_MSB+1];

   ms_timebase #(
      .CLKS_PER_MS (CLKS_PER_MS),
      .MS_W        (MS_W)
   ) u_timebase (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (run),
      .hold    (hold),
      .clear   (rewind),
      .song_ms (song_ms)
   );

   // Extra bit keeps song_ms + LEAD_MS from overflowing near saturation;
   // compares against the registered (pre-increment) song_ms
   assign spawn_ok = ({1'b0, song_ms} + LEAD_EXT) >= {1'b0, entry_ms_reg};

   // Next-state and spawn decode; rewind preempts every state
   always_comb begin
      state_next       = state_reg;
      rom_addr_next    = rom_addr_reg;
      entry_lanes_next = entry_lanes_reg;
      entry_ms_next    = entry_ms_reg;
      note_valid_next  = 1'b0;
      note_lanes_next  = note_lanes_reg;
      note_hit_ms_next = note_hit_ms_reg;
      if (rewind) begin
         state_next    = IDLE;
         rom_addr_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               rom_addr_next = '0;
               if (run) state_next = FETCH;
            end
            FETCH: state_next = WAIT;
            WAIT: begin
               entry_lanes_next = rom_data[LANES_MSB:LANES_LSB];
               entry_ms_next    = MS_W'(rom_data[HIT_MSB:0]);
               state_next       = (rom_data[LANES_MSB:LANES_LSB] == CHART_END) ? DONE : ARMED;
            end
            ARMED: begin
               if (run && spawn_ok) begin
                  note_valid_next  = 1'b1;
                  note_lanes_next  = entry_lanes_reg;
                  note_hit_ms_next = entry_ms_reg;
                  if (rom_addr_reg == ADDR_MAX) begin
                     state_next = DONE;
                  end else begin
                     rom_addr_next = rom_addr_reg + 1'b1;
                     state_next    = FETCH;
                  end
               end
            end
            DONE: state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         rom_addr_reg    <= '0;
         entry_lanes_reg <= '0;
         entry_ms_reg    <= '0;
         note_valid_reg  <= 1'b0;
         note_lanes_reg  <= '0;
         note_hit_ms_reg <= '0;
      end else begin
         state_reg       <= state_next;
         rom_addr_reg    <= rom_addr_next;
         entry_lanes_reg <= entry_lanes_next;
         entry_ms_reg    <= entry_ms_next;
         note_valid_reg  <= note_valid_next;
         note_lanes_reg  <= note_lanes_next;
         note_hit_ms_reg <= note_hit_ms_next;
      end
   end

   assign rom_addr    = rom_addr_reg;
   assign note_valid  = note_valid_reg;
   assign note_lanes  = note_lanes_reg;
   assign note_hit_ms = note_hit_ms_reg;
   assign chart_done  = (state_reg == DONE);

endmodule

// File: tb/tb_note_scheduler.sv
// Randomized and directed bench for note_scheduler with a millisecond/ordering
// reference model.
module tb_note_scheduler;
   import dd_pkg::*;

   localparam int CPM  = 4;
   localparam int LEAD = 10;
   localparam int AW   = 4;
   localparam int MW   = 20;
   localparam int NENT = 1 << AW;

   logic          clock;
   logic          reset_n;
   logic          game_active;
   logic          show_pause_screen;
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data;
   logic          note_valid;
   logic [3:0]    note_lanes;
   logic [MW-1:0] note_hit_ms;
   logic [MW-1:0] song_ms;
   logic          chart_done;

   logic [31:0] rom_mem [NENT];

   int n_checks = 0;
   int n_fail   = 0;
   int run_cnt  = 0;    // run cycles since last rewind/reset
   int note_idx = 0;    // next chart entry expected to spawn
   int n_notes  = 0;    // entries before end marker
   int last_cmp = 0;    // song_ms at the previous spawn decision
   int pulse_ms[$];     // observed song_ms at each pulse of the current scenario

   note_scheduler #(
      .CLKS_PER_MS (CPM),
      .LEAD_MS     (LEAD),
      .ADDR_W      (AW),
      .MS_W        (MW)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .game_active       (game_active),
      .show_pause_screen (show_pause_screen),
      .rom_addr          (rom_addr),
      .rom_data          (rom_data),
      .note_valid        (note_valid),
      .note_lanes        (note_lanes),
      .note_hit_ms       (note_hit_ms),
      .song_ms           (song_ms),
      .chart_done        (chart_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Chart ROM with one cycle read latency
   always @(posedge clock) rom_data <= rom_mem[rom_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ent(input int lanes, input int hit);
      logic [3:0]  l;
      logic [19:0] h;
      l = lanes[3:0];
      h = hit[19:0];
      return {l, 8'h00, h};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < NENT; i++) rom_mem[i] = 32'h0;
   endtask

   task automatic count_notes();
      n_notes = 0;
      while (n_notes < NENT && rom_mem[n_notes][31:28] != CHART_END) n_notes++;
   endtask

   // One clock: apply inputs, advance the model, check time and any pulse
   task automatic tick(input logic ga, input logic sp);
      int prev_ms, bnd, hit, lanes;
      game_active       = ga;
      show_pause_screen = sp;
      prev_ms = run_cnt / CPM;
      @(posedge clock);
      #1;
      if (!reset_n || (!ga && !sp)) begin
         run_cnt  = 0;
         note_idx = 0;
         last_cmp = 0;
      end else if (ga) begin
         run_cnt++;
      end
      chk("song_ms", song_ms, run_cnt / CPM);
      if (note_valid) begin
         pulse_ms.push_back(int'(song_ms));
         chk("pulse_while_run", {31'b0, ga}, 1);
         if (note_idx < n_notes) begin
            lanes = int'(rom_mem[note_idx][31:28]);
            hit   = int'(rom_mem[note_idx][19:0]);
            chk("note_lanes", note_lanes, lanes);
            chk("note_hit_ms", note_hit_ms, hit);
            chk("spawn_not_early", {31'b0, (prev_ms + LEAD >= hit)}, 1);
            bnd = hit - LEAD;
            if (last_cmp + 1 > bnd) bnd = last_cmp + 1;
            chk("spawn_not_late", {31'b0, (prev_ms <= bnd)}, 1);
            last_cmp = prev_ms;
            note_idx++;
         end else begin
            chk("extra_pulse", note_idx + 1, n_notes);
         end
      end
   endtask

   task automatic start_scenario();
      tick(1'b0, 1'b0);
      pulse_ms.delete();
      count_notes();
   endtask

   task automatic run_until_done(input int bound);
      int n;
      n = 0;
      while (!chart_done && n < bound) begin
         tick(1'b1, 1'b0);
         n++;
      end
      chk("done_reached", {31'b0, chart_done}, 1);
      chk("note_count", note_idx, n_notes);
   endtask

   initial begin
      int n, h, r;
      reset_n = 1'b0;
      game_active = 1'b0;
      show_pause_screen = 1'b0;
      clear_rom();
      count_notes();

      // Reset then idle
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 1'b0);
         chk("idle_valid", {31'b0, note_valid}, 0);
         chk("idle_addr", rom_addr, 0);
         chk("idle_done", {31'b0, chart_done}, 0);
      end
      chk("idle_lanes", note_lanes, 0);
      chk("idle_hit", note_hit_ms, 0);

      // Basic spawn
      clear_rom();
      rom_mem[0] = ent(1 << LANE_R, 100);
      rom_mem[1] = ent(1 << LANE_U, 105);
      start_scenario();
      run_until_done(1000);
      chk("basic_pulses", pulse_ms.size(), 2);
      if (pulse_ms.size() == 2) begin
         chk("basic_ms0", pulse_ms[0], 90);
         chk("basic_ms1", pulse_ms[1], 95);
      end

      // Early chord entries
      clear_rom();
      rom_mem[0] = ent((1 << LANE_L) | (1 << LANE_D) | (1 << LANE_U) | (1 << LANE_R), 3);
      rom_mem[1] = ent(1 << LANE_L, 3);
      start_scenario();
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
      chk("early_pulses_8cyc", pulse_ms.size(), 2);
      run_until_done(100);

      // Pause at 80 ms
      clear_rom();
      rom_mem[0] = ent(1 << LANE_R, 100);
      start_scenario();
      n = 0;
      while (run_cnt / CPM < 80 && n < 1000) begin
         tick(1'b1, 1'b0);
         n++;
      end
      for (int i = 0; i < 1000; i++) tick(1'b0, 1'b1);
      chk("pause_ms", song_ms, 80);
      chk("pause_no_pulse", pulse_ms.size(), 0);
      run_until_done(1000);
      if (pulse_ms.size() > 0) chk("resume_ms", pulse_ms[0], 90);

      // Rewind mid-song while in WAIT
      clear_rom();
      rom_mem[0] = ent(1 << LANE_U, 60);
      rom_mem[1] = ent(1 << LANE_R, 100);
      start_scenario();
      n = 0;
      while (pulse_ms.size() == 0 && n < 1000) begin
         tick(1'b1, 1'b0);
         n++;
      end
      chk("rw_pulse_seen", pulse_ms.size(), 1);
      if (pulse_ms.size() > 0) chk("rw_pulse_ms", pulse_ms[0], 50);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("rw_addr", rom_addr, 0);
      chk("rw_done", {31'b0, chart_done}, 0);
      pulse_ms.delete();
      run_until_done(1000);
      if (pulse_ms.size() > 0) chk("rw_replay_ms", pulse_ms[0], 50);

      // No end marker: 16 entries at hit 0
      clear_rom();
      for (int i = 0; i < NENT; i++) rom_mem[i] = ent($urandom_range(1, 15), 0);
      start_scenario();
      run_until_done(200);
      chk("full_pulses", pulse_ms.size(), NENT);
      chk("addr_no_wrap", rom_addr, NENT - 1);
      // Reset mid-stream
      start_scenario();
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
      reset_n = 1'b0;
      tick(1'b1, 1'b0);
      chk("rst_valid", {31'b0, note_valid}, 0);
      chk("rst_lanes", note_lanes, 0);
      chk("rst_hit", note_hit_ms, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_done", {31'b0, chart_done}, 0);
      reset_n = 1'b1;

      // Randomized charts with random run/pause/rewind traffic
      for (int it = 0; it < 20; it++) begin
         clear_rom();
         n = (it % 5 == 4) ? NENT : $urandom_range(1, 15);
         h = $urandom_range(0, 20);
         for (int i = 0; i < n; i++) begin
            h = h + $urandom_range(0, 8) - 2;
            if (h < 0) h = 0;
            rom_mem[i] = ent($urandom_range(1, 15), h);
         end
         start_scenario();
         for (int c = 0; c < 300; c++) begin
            r = $urandom_range(0, 99);
            if (r < 75)      tick(1'b1, 1'($urandom_range(0, 1)));
            else if (r < 97) tick(1'b0, 1'b1);
            else             tick(1'b0, 1'b0);
         end
         run_until_done(3000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
